// File: rtl/inst_stream_encoder_if.sv
// Descriptor stream from the program-loader front end plus the instruction-memory write bus.
interface inst_stream_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [2:0]        in_func3;
  logic              in_sub;
  logic [14:0]       in_operand;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_class, in_func3, in_sub, in_operand,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_func3, in_sub, in_operand,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_stream_encoder.sv
// Packs instruction descriptors into 32-bit words and writes them sequentially into
// instruction memory; a session ends on HLT, on the last address, or on abort.
module inst_stream_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  inst_stream_encoder_if.slave bus,
  output logic [ADDR_W:0]     count,
  output logic                done,
  output logic                full,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept, legal, is_nop, is_hlt, last;
  logic [6:0]        opcode, fn7;
  logic [2:0]        fn3;
  logic [31:0]       word;

  always_comb begin
    legal  = 1'b1;
    is_nop = 1'b0;
    is_hlt = 1'b0;
    opcode = '0;
    fn3    = '0;
    fn7    = '0;
    case (bus.in_class)
      4'd0:  is_nop = 1'b1;
      4'd1:  begin opcode = 7'b0010011; fn3 = bus.in_func3; end
      4'd2:  begin
        opcode = 7'b0110011;
        fn3    = bus.in_func3;
        if (bus.in_func3 == 3'd0) fn7 = {bus.in_sub, 6'b0};
      end
      4'd3:  opcode = 7'b0110111;
      4'd4:  opcode = 7'b0000011;
      4'd5:  opcode = 7'b0100011;
      4'd6:  begin
        opcode = 7'b1100011;
        fn3    = bus.in_func3;
        if (bus.in_func3 == 3'd2 || bus.in_func3 == 3'd3) legal = 1'b0;
      end
      4'd7:  opcode = 7'b1100111;
      4'd8:  opcode = 7'b1101111;
      4'd9:  opcode = 7'b1101011;
      4'd10: begin opcode = 7'b1111111; is_hlt = 1'b1; end
      default: legal = 1'b0;
    endcase
    word = is_nop ? '0 : {bus.in_operand, fn7, fn3, opcode};
  end

  // The low bits of count double as the write pointer; the session ends before it could wrap.
  assign last   = (count_q[ADDR_W-1:0] == '1);
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (abort)                                    state_d = S_IDLE;
        else if (accept && legal && (is_hlt || last)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == S_LOAD) && !abort;
    done         = (state_q == S_DONE);
  end

  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    if (state_q == S_IDLE && start) begin
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end
    if (accept) begin
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = word;
        count_d = count_q + 1'b1;
        if (last) full_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign full           = full_q;
  assign err            = err_q;

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Bench for inst_stream_encoder: an ADDR_W=8 and an ADDR_W=2 instance share the descriptor
// drive; writes are collected by a monitor and compared with a descriptor-level model.
module tb_inst_stream_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start8, start2, abort_r;
  logic        drv_valid, drv_sub;
  logic [3:0]  drv_class;
  logic [2:0]  drv_f3;
  logic [14:0] drv_op;
  logic [8:0]  count8;
  logic [2:0]  count2;
  logic        done8, full8, err8, done2, full2, err2;

  inst_stream_encoder_if #(.ADDR_W(8)) if8 ();
  inst_stream_encoder_if #(.ADDR_W(2)) if2 ();

  assign if8.in_valid = drv_valid;   assign if2.in_valid = drv_valid;
  assign if8.in_class = drv_class;   assign if2.in_class = drv_class;
  assign if8.in_func3 = drv_f3;      assign if2.in_func3 = drv_f3;
  assign if8.in_sub = drv_sub;       assign if2.in_sub = drv_sub;
  assign if8.in_operand = drv_op;    assign if2.in_operand = drv_op;

  inst_stream_encoder #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort_r), .bus(if8),
    .count(count8), .done(done8), .full(full8), .err(err8)
  );
  inst_stream_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort_r), .bus(if2),
    .count(count2), .done(done2), .full(full2), .err(err2)
  );

  typedef struct { logic dn; int addr; logic [31:0] data; } wr_t;
  typedef struct { logic [3:0] c; logic [2:0] f3; logic sub; logic [14:0] op; } desc_t;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t act8[$];
  wr_t act2[$];
  int  dn8 = 0;
  int  dn2 = 0;

  always @(negedge clk) begin
    if (if8.imem_we) act8.push_back('{dn: done8, addr: int'(if8.imem_addr), data: if8.imem_wdata});
    if (if2.imem_we) act2.push_back('{dn: done2, addr: int'(if2.imem_addr), data: if2.imem_wdata});
    if (done8) dn8++;
    if (done2) dn2++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: opcode per class, func3 only for IARITH/RARITH/BRANCH, func7 only for RARITH func3=0.
  function automatic bit ref_enc(input desc_t d, output logic [31:0] w, output bit hlt);
    int unsigned opc[11] = '{'h00, 'h13, 'h33, 'h37, 'h03, 'h23, 'h63, 'h67, 'h6F, 'h6B, 'h7F};
    int unsigned f3, f7;
    w   = 32'd0;
    hlt = (d.c == 4'd10);
    if (d.c > 4'd10) return 1'b0;
    if (d.c == 4'd6 && (d.f3 == 3'd2 || d.f3 == 3'd3)) return 1'b0;
    if (d.c == 4'd0) return 1'b1;
    f3 = (d.c == 4'd1 || d.c == 4'd2 || d.c == 4'd6) ? int'(d.f3) : 0;
    f7 = (d.c == 4'd2 && d.f3 == 3'd0 && d.sub) ? 64 : 0;
    w  = 32'(d.op) * 32'd131072 + 32'(f7) * 32'd1024 + 32'(f3) * 32'd128 + 32'(opc[d.c]);
    return 1'b1;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if8.in_ready : if2.in_ready;
  endfunction
  function automatic int act_size(input int sel);
    return (sel == 0) ? act8.size() : act2.size();
  endfunction
  function automatic wr_t act_at(input int sel, input int i);
    return (sel == 0) ? act8[i] : act2[i];
  endfunction

  function automatic desc_t gen_desc(input bit allow_hlt);
    desc_t d;
    int unsigned r = $urandom_range(0, 99);
    d.f3  = 3'($urandom);
    d.sub = 1'($urandom);
    d.op  = 15'($urandom);
    if (r < 8)                   d.c = 4'($urandom_range(11, 15));
    else if (allow_hlt && r < 13) d.c = 4'd10;
    else                         d.c = 4'($urandom_range(0, 9));
    return d;
  endfunction

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start8 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    start2 = 1'b0;
  endtask

  // Drives one descriptor and holds it until accepted or the wait budget runs out.
  task automatic send(input int sel, input desc_t d, input int max_wait, output bit acc);
    acc = 1'b0;
    @(negedge clk);
    drv_valid = 1'b1; drv_class = d.c; drv_f3 = d.f3; drv_sub = d.sub; drv_op = d.op;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (rdy(sel)) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_session(input int sel, input desc_t ds[$], input int gap_max,
                             input string name, output int base_o);
    int    depth, ptr, dbase, n_send, k;
    bit    stopped, e_err, acc, hlt, lg;
    logic  [31:0] w;
    wr_t   exp_q[$];
    wr_t   a;
    depth = (sel == 0) ? 256 : 4;
    pulse_start(sel);
    base_o = act_size(sel);
    dbase  = (sel == 0) ? dn8 : dn2;
    ptr = 0; stopped = 1'b0; e_err = 1'b0; n_send = 0;
    foreach (ds[i]) begin
      if (stopped) break;
      n_send++;
      lg = ref_enc(ds[i], w, hlt);
      if (!lg) e_err = 1'b1;
      else begin
        exp_q.push_back('{dn: (hlt || ptr == depth - 1), addr: ptr, data: w});
        ptr++;
        if (hlt || ptr == depth) stopped = 1'b1;
      end
    end
    for (int i = 0; i < n_send; i++) begin
      if (gap_max > 0) begin
        k = $urandom_range(0, gap_max);
        repeat (k) begin @(negedge clk); drv_valid = 1'b0; end
      end
      send(sel, ds[i], 4, acc);
      n_cmp++;
      if (acc !== 1'b1) begin n_err++; $display("FAIL %s accept[%0d]: accepted=%0d required=1", name, i, acc); end
    end
    if (stopped && n_send < ds.size()) begin
      send(sel, ds[n_send], 3, acc);
      n_cmp++;
      if (acc !== 1'b0) begin n_err++; $display("FAIL %s post_end_accept: accepted=%0d required=0", name, acc); end
    end
    @(negedge clk);
    drv_valid = 1'b0;
    if (!stopped) begin abort_r = 1'b1; @(negedge clk); abort_r = 1'b0; end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (act_size(sel) - base_o !== exp_q.size()) begin
      n_err++; $display("FAIL %s writes: got %0d required %0d", name, act_size(sel) - base_o, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        a = act_at(sel, base_o + i);
        n_cmp++;
        if (a.addr !== exp_q[i].addr || a.data !== exp_q[i].data || a.dn !== exp_q[i].dn) begin
          n_err++;
          $display("FAIL %s write[%0d]: got a=%0d d=%08h done=%0b required a=%0d d=%08h done=%0b",
                   name, i, a.addr, a.data, a.dn, exp_q[i].addr, exp_q[i].data, exp_q[i].dn);
        end
      end
    end
    n_cmp++;
    if ((sel == 0 ? int'(count8) : int'(count2)) !== ptr) begin
      n_err++; $display("FAIL %s count: got %0d required %0d", name, (sel == 0 ? int'(count8) : int'(count2)), ptr);
    end
    n_cmp++;
    if ((sel == 0 ? full8 : full2) !== (ptr == depth)) begin
      n_err++; $display("FAIL %s full: got %0b required %0b", name, (sel == 0 ? full8 : full2), (ptr == depth));
    end
    n_cmp++;
    if ((sel == 0 ? err8 : err2) !== e_err) begin
      n_err++; $display("FAIL %s err: got %0b required %0b", name, (sel == 0 ? err8 : err2), e_err);
    end
    n_cmp++;
    if ((sel == 0 ? dn8 : dn2) - dbase !== int'(stopped)) begin
      n_err++; $display("FAIL %s done_pulses: got %0d required %0d", name, (sel == 0 ? dn8 : dn2) - dbase, int'(stopped));
    end
    n_cmp++;
    if (rdy(sel) !== 1'b0) begin n_err++; $display("FAIL %s idle_ready: got %0b required 0", name, rdy(sel)); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if8.in_ready, if8.imem_we, if8.imem_addr, if8.imem_wdata, count8, done8, full8, err8} !== 54'd0) begin
      n_err++; $display("FAIL reset_values: got rdy=%0b we=%0b a=%0h d=%08h cnt=%0d dn=%0b f=%0b e=%0b required all 0",
                        if8.in_ready, if8.imem_we, if8.imem_addr, if8.imem_wdata, count8, done8, full8, err8);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if8.in_ready, if2.in_ready, if8.imem_we, if2.imem_we, count2, done2} !== 9'd0) begin
      n_err++; $display("FAIL reset_idle: got rdy8=%0b rdy2=%0b we8=%0b we2=%0b cnt2=%0d dn2=%0b required all 0",
                        if8.in_ready, if2.in_ready, if8.imem_we, if2.imem_we, count2, done2);
    end
  endtask

  task automatic test_basic();
    desc_t ds[$];
    int    b;
    ds.push_back('{c: 4'd2, f3: 3'd0, sub: 1'b1, op: 15'd0});
    ds.push_back('{c: 4'd10, f3: 3'd0, sub: 1'b0, op: 15'd0});
    run_session(0, ds, 0, "basic", b);
    n_cmp++;
    if (act8.size() < b + 2 || act8[b].data !== 32'h00010033 || act8[b + 1].data !== 32'h0000007F ||
        act8[b + 1].addr !== 1 || act8[b + 1].dn !== 1'b1) begin
      n_err++; $display("FAIL basic_words: got %0d writes, required 00010033@0 then 0000007F@1 with done", act8.size() - b);
    end
  endtask

  task automatic test_encodings();
    desc_t ds[$];
    int    b;
    ds.push_back('{c: 4'd1, f3: 3'd5, sub: 1'b0, op: 15'h7FFF});
    ds.push_back('{c: 4'd3, f3: 3'd7, sub: 1'b1, op: 15'd1});
    ds.push_back('{c: 4'd10, f3: 3'd6, sub: 1'b1, op: 15'h1234});
    run_session(0, ds, 1, "encodings", b);
    n_cmp++;
    if (act8.size() < b + 3 || act8[b].data !== 32'hFFFE0293 || act8[b + 1].data !== 32'h00020037 ||
        act8[b + 2].data !== 32'h2468007F) begin
      n_err++; $display("FAIL encodings_words: got %0d writes, required FFFE0293, 00020037, 2468007F", act8.size() - b);
    end
  endtask

  task automatic test_illegal();
    desc_t ds[$];
    int    b;
    ds.push_back('{c: 4'd6, f3: 3'd2, sub: 1'b0, op: 15'h55});
    ds.push_back('{c: 4'd12, f3: 3'd0, sub: 1'b0, op: 15'h66});
    ds.push_back('{c: 4'd6, f3: 3'd4, sub: 1'b0, op: 15'd0});
    run_session(0, ds, 0, "illegal", b);
    n_cmp++;
    if (act8.size() !== b + 1 || act8[b].data !== 32'h00000263 || act8[b].addr !== 0 || err8 !== 1'b1 || count8 !== 9'd1) begin
      n_err++; $display("FAIL illegal_result: got writes=%0d err=%0b count=%0d required 1 write of 00000263@0 err=1 count=1",
                        act8.size() - b, err8, count8);
    end
  endtask

  task automatic test_full();
    desc_t ds[$];
    int    b;
    for (int i = 0; i < 5; i++) ds.push_back('{c: 4'd1, f3: 3'($urandom), sub: 1'b0, op: 15'($urandom)});
    run_session(1, ds, 0, "full_small", b);
    n_cmp++;
    if (act2.size() !== b + 4 || act2[b + 3].addr !== 3 || act2[b + 3].dn !== 1'b1 || full2 !== 1'b1 || count2 !== 3'd4) begin
      n_err++; $display("FAIL full_small_result: got writes=%0d full=%0b count=%0d required 4 writes, done at addr 3, full=1, count=4",
                        act2.size() - b, full2, count2);
    end
  endtask

  task automatic test_abort();
    desc_t d;
    bit    acc;
    int    b, db;
    pulse_start(0);
    b = act8.size(); db = dn8;
    d = '{c: 4'd1, f3: 3'd0, sub: 1'b0, op: 15'h12};
    send(0, d, 4, acc);
    d.op = 15'h34;
    send(0, d, 4, acc);
    d.c = 4'd13;
    send(0, d, 4, acc);
    @(negedge clk);
    abort_r = 1'b1; drv_valid = 1'b1; drv_class = 4'd1;
    #1;
    n_cmp++;
    if (if8.in_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %0b required 0", if8.in_ready); end
    @(negedge clk);
    abort_r = 1'b0; drv_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (act8.size() - b !== 2 || count8 !== 9'd2 || err8 !== 1'b1 || dn8 !== db || if8.in_ready !== 1'b0) begin
      n_err++; $display("FAIL abort_state: got writes=%0d count=%0d err=%0b dones=%0d rdy=%0b required 2/2/1/0/0",
                        act8.size() - b, count8, err8, dn8 - db, if8.in_ready);
    end
    pulse_start(0);
    n_cmp++;
    if (count8 !== 9'd0 || err8 !== 1'b0 || full8 !== 1'b0 || if8.in_ready !== 1'b1) begin
      n_err++; $display("FAIL restart_clear: got count=%0d err=%0b full=%0b rdy=%0b required 0/0/0/1",
                        count8, err8, full8, if8.in_ready);
    end
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
  endtask

  task automatic test_random();
    desc_t ds[$];
    int    b, sel;
    for (int s = 0; s < 8; s++) begin
      sel = s % 2;
      ds.delete();
      for (int i = 0; i < int'($urandom_range(1, (sel == 0) ? 40 : 10)); i++) ds.push_back(gen_desc(1'b1));
      run_session(sel, ds, 2, (sel == 0) ? "random8" : "random2", b);
    end
    ds.delete();
    for (int i = 0; i < 300; i++) ds.push_back(gen_desc(1'b0));
    run_session(0, ds, 0, "fill8", b);
    ds.delete();
    for (int i = 0; i < 12; i++) ds.push_back(gen_desc(1'b0));
    run_session(1, ds, 1, "fill2", b);
  endtask

  task automatic test_reset_mid();
    desc_t d;
    bit    acc;
    int    b;
    pulse_start(0);
    d = '{c: 4'd1, f3: 3'd1, sub: 1'b0, op: 15'h7};
    send(0, d, 4, acc);
    send(0, d, 4, acc);
    #2;
    rst_n = 1'b0;
    #1;
    b = act8.size();
    n_cmp++;
    if ({if8.in_ready, if8.imem_we, if8.imem_addr, if8.imem_wdata, count8, done8, full8, err8} !== 54'd0) begin
      n_err++; $display("FAIL midreset_values: got rdy=%0b we=%0b a=%0h d=%08h cnt=%0d dn=%0b f=%0b e=%0b required all 0",
                        if8.in_ready, if8.imem_we, if8.imem_addr, if8.imem_wdata, count8, done8, full8, err8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (act8.size() !== b || if8.in_ready !== 1'b0) begin
      n_err++; $display("FAIL midreset_quiet: got writes=%0d rdy=%0b required 0 writes rdy=0", act8.size() - b, if8.in_ready);
    end
    drv_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0; abort_r = 1'b0;
    drv_valid = 1'b0; drv_class = '0; drv_f3 = '0; drv_sub = 1'b0; drv_op = '0;
    test_reset();
    test_basic();
    test_encodings();
    test_illegal();
    test_full();
    test_abort();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_stream_encoder.md
Name: inst_stream_encoder

Overview:
- Encoder counterpart to the control unit decoder: accepts instruction descriptions (class, func3, sub, operand) over a valid/ready stream and packs them into 32-bit instruction words.
- Writes the words sequentially into instruction memory.
- Sits between the test/program-loader front end and the instruction memory.
- Stops on the first HLT, on memory full, or on abort.

Parameters:
- ADDR_W, 8: instruction memory address width; depth = 2**ADDR_W words.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a load session (honoured in IDLE only).
- abort, input, 1: terminate session; honoured in LOAD.
- in_valid, input, 1: descriptor valid.
- in_ready, output, 1: descriptor accepted when in_valid && in_ready.
- in_class, input, 4: 0 NOP, 1 IARITH, 2 RARITH, 3 LUI, 4 LOAD, 5 STORE, 6 BRANCH, 7 J, 8 JAL, 9 JALR, 10 HLT; 11-15 illegal.
- in_func3, input, 3: func3 for IARITH/RARITH/BRANCH.
- in_sub, input, 1: RARITH func3=0 subtract select.
- in_operand, input, 15: opaque operand field, packed into word[31:17].
- imem_we, output, 1: instruction memory write strobe.
- imem_addr, output, ADDR_W: write address.
- imem_wdata, output, 32: encoded word.
- count, output, ADDR_W+1: words written this session.
- done, output, 1: one-cycle pulse at session end (HLT or full).
- full, output, 1: session ended because memory filled; held until next start.
- err, output, 1: sticky; an illegal descriptor was seen this session.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, full=0, err=0, write pointer=0.
- Reset mid-session aborts immediately; no partial write completes.

FSM states and transitions:
- IDLE: start=1 -> LOAD; clears pointer, count, full and err.
- LOAD: accepts descriptors as described below.
- DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.

in_ready:
- in_ready = (state==LOAD) && !abort, derived from registered state.
- abort in LOAD -> IDLE next cycle. No write, no done pulse; count and err retained.
- abort together with in_valid: abort wins and the descriptor is not accepted.

Encoding: opcode[6:0], func3[9:7], func7[16:10], operand[31:17].
- Opcodes:
  - NOP: word = 0; operand dropped.
  - IARITH: 0010011.
  - RARITH: 0110011.
  - LUI: 0110111.
  - LOAD: 0000011.
  - STORE: 0100011.
  - BRANCH: 1100011.
  - J: 1100111.
  - JAL: 1101111.
  - JALR: 1101011.
  - HLT: 1111111.
- func3 field: in_func3 for IARITH, RARITH and BRANCH; 0 for all other classes.
- func7 field: {in_sub,6'b0} only for RARITH with func3=0; 0 otherwise.
- Illegal descriptors: class 11-15, and BRANCH with func3 2 or 3.
  - Accepted (handshake completes) but not written.
  - err set; pointer and count unchanged.

Legal accept (1-cycle latency):
- Next cycle: imem_we=1, imem_addr=pointer, imem_wdata=word.
- pointer+1, count+1.
- imem_we is low in every cycle without a write; imem_addr/imem_wdata hold their last values.

Termination:
- HLT accepted: HLT word is written, then state -> DONE.
- Any legal accept writing address 2**ADDR_W-1 (and not HLT): state -> DONE with full=1.
- HLT written at the last address: full=1 as well.
- Terminating accept: in_ready drops the next cycle; the write strobe and the done pulse occur in the same cycle.
- Pointer never wraps within a session; count reaches 2**ADDR_W at full.
- Back-to-back accepts every cycle are required (throughput 1 word/clk).

Test Plan:
- Reset then start, RARITH func3=0 sub=1 operand=0, then HLT -> writes 0x00010033 at addr 0, 0x0000007F at addr 1; done pulses with the second write; count=2; full=0; err=0.
- IARITH func3=5 operand=15'h7FFF -> imem_wdata=0xFFFE0293; LUI func3=7 operand=1 -> 0x00020037 (func3 forced 0).
- BRANCH func3=2, then class 12, then BRANCH func3=4 operand=0 -> only 0x00000263 written at addr 0; err=1; count=1.
- ADDR_W=2, five IARITH descriptors streamed with in_valid held high -> 4 writes at addrs 0-3; done at 4th write; full=1; in_ready=0 afterwards; 5th descriptor not accepted.
- abort asserted in the same cycle as in_valid after 2 writes -> descriptor not accepted; no done; state IDLE; count=2; new start clears count/err.
- rst_n pulled low mid-LOAD with in_valid high -> all outputs return to reset values asynchronously; no imem_we after reset release until start.
